// File: rtl/chnl_rx.sv
// chnl_rx: RIFFA CHNL receiver. Host beats are buffered in a beat FIFO that
// records how many words of each beat belong to the transfer. A word gearbox
// then drops the padding words and repacks the stream into RX_WIDTH-bit words
// on a valid/ready output. Leftover words are carried into the next transfer.
module chnl_rx #(
   parameter int C_PCI_DATA_WIDTH = 64,
   parameter int RX_WIDTH         = 32,
   parameter int FIFO_DEPTH       = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        CHNL_RX_CLK,
   input  logic                        CHNL_RX,
   output logic                        CHNL_RX_ACK,
   input  logic                        CHNL_RX_LAST,
   input  logic [31:0]                 CHNL_RX_LEN,
   input  logic [30:0]                 CHNL_RX_OFF,
   input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
   input  logic                        CHNL_RX_DATA_VALID,
   output logic                        CHNL_RX_DATA_REN,
   output logic                        o_val,
   input  logic                        o_rdy,
   output logic [RX_WIDTH-1:0]         o_data
);
   localparam int W   = C_PCI_DATA_WIDTH / 32;
   localparam int R   = RX_WIDTH / 32;
   localparam int CAP = R + W;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int NW  = $clog2(W + 1);
   localparam logic [31:0] W32   = 32'(W);
   localparam logic [31:0] R32   = 32'(R);
   localparam logic [31:0] CAP32 = 32'(CAP);
   localparam logic [AW:0] DEPTH_P = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_RECV, S_DONE} state_t;

   state_t                      state, state_next;
   logic [31:0]                 words_left, words_left_next;
   logic [31:0]                 take;
   logic                        push;

   logic [C_PCI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [NW-1:0]               mem_n [FIFO_DEPTH];
   logic [AW:0]                 wr_ptr, rd_ptr, fifo_count;
   logic                        fifo_full, fifo_empty, pop;
   logic [C_PCI_DATA_WIDTH-1:0] beat_masked;

   logic [CAP*32-1:0]           gbuf, gbuf_next;
   logic [31:0]                 held, held_rem, held_next, pop_n;
   logic                        out_fire;
   logic                        unused_inputs;

   assign CHNL_RX_CLK   = clk;
   assign unused_inputs = ^{CHNL_RX_LAST, CHNL_RX_OFF};

   assign fifo_count = wr_ptr - rd_ptr;
   assign fifo_full  = (fifo_count == DEPTH_P);
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign take       = (words_left < W32) ? words_left : W32;
   assign push       = CHNL_RX_DATA_REN && CHNL_RX_DATA_VALID;

   assign o_val  = (held >= R32);
   assign o_data = gbuf[RX_WIDTH-1:0];

   // Transfer state and remaining word count, cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         words_left <= '0;
      end else begin
         state      <= state_next;
         words_left <= words_left_next;
      end
   end

   // Handshake sequencing: capture length, ack once, accept beats, wait for host to drop
   always_comb begin
      state_next       = state;
      words_left_next  = words_left;
      CHNL_RX_ACK      = 1'b0;
      CHNL_RX_DATA_REN = 1'b0;
      case (state)
         S_IDLE: begin
            if (CHNL_RX) begin
               words_left_next = CHNL_RX_LEN;
               state_next      = S_ACK;
            end
         end
         S_ACK: begin
            CHNL_RX_ACK = 1'b1;
            state_next  = (words_left == '0) ? S_DONE : S_RECV;
         end
         S_RECV: begin
            CHNL_RX_DATA_REN = !fifo_full;
            if (CHNL_RX_DATA_VALID && !fifo_full) begin
               words_left_next = words_left - take;
               if (words_left == take)
                  state_next = S_DONE;
               else if (!CHNL_RX)
                  state_next = S_IDLE;
            end else if (!CHNL_RX) begin
               state_next = S_IDLE;
            end
         end
         S_DONE: begin
            if (!CHNL_RX)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Zero the padding words of an incoming beat so the gearbox can OR-merge it
   always_comb begin
      beat_masked = '0;
      for (int k = 0; k < W; k++) begin
         if (32'(k) < take)
            beat_masked[32*k +: 32] = CHNL_RX_DATA[32*k +: 32];
      end
   end

   // Beat FIFO storage; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]]   <= beat_masked;
         mem_n[wr_ptr[AW-1:0]] <= take[NW-1:0];
      end
   end

   // Beat FIFO pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Gearbox: retire R words on handshake, then append the head beat if it fits
   always_comb begin
      out_fire  = o_val && o_rdy;
      held_rem  = out_fire ? (held - R32) : held;
      pop       = !fifo_empty && ((held_rem + W32) <= CAP32);
      pop_n     = pop ? 32'(mem_n[rd_ptr[AW-1:0]]) : '0;
      held_next = held_rem + pop_n;
      gbuf_next = out_fire ? (gbuf >> RX_WIDTH) : gbuf;
      if (pop)
         gbuf_next = gbuf_next |
                     ({{((CAP - W) * 32){1'b0}}, mem[rd_ptr[AW-1:0]]} << (held_rem << 5));
   end

   // Gearbox residue register; words above the held count are kept at zero
   always_ff @(posedge clk) begin
      if (rst) begin
         gbuf <= '0;
         held <= '0;
      end else begin
         gbuf <= gbuf_next;
         held <= held_next;
      end
   end
endmodule

// File: tb/tb_chnl_rx.sv
// Testbench for chnl_rx: a host-side driver feeds two instances (RX_WIDTH=32
// and RX_WIDTH=96) and a word-queue scoreboard checks every output word.
module tb_chnl_rx;
   localparam int PCI_W = 64;
   localparam int W     = PCI_W / 32;
   localparam int DEPTH = 16;

   typedef struct {
      int unsigned len;
      int          beats;
      int          outs;
      bit          ren;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              chnl_rx, chnl_rx_last;
   logic [31:0]       chnl_rx_len;
   logic [30:0]       chnl_rx_off;
   logic [PCI_W-1:0]  chnl_rx_data;
   logic              chnl_rx_data_valid;
   logic              rx_clk1, ack1, ren1, o_val1, o_rdy1;
   logic [31:0]       o_data1;
   logic              rx_clk3, ack3, ren3, o_val3, o_rdy3, valid3;
   logic [95:0]       o_data3;

   logic [31:0]       exp1[$];
   logic [31:0]       exp3[$];
   int                vectors = 0;
   int                miscompares = 0;
   int                ack_count = 0;
   int                out_cnt1 = 0;
   int                out_cnt3 = 0;
   int                beats_total = 0;
   int                rdy_mode = 0;

   always #5 clk = ~clk;

   assign o_rdy3 = 1'b1;
   assign valid3 = chnl_rx_data_valid & ren1;

   chnl_rx #(.C_PCI_DATA_WIDTH(PCI_W), .RX_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .CHNL_RX_CLK(rx_clk1), .CHNL_RX(chnl_rx),
      .CHNL_RX_ACK(ack1), .CHNL_RX_LAST(chnl_rx_last), .CHNL_RX_LEN(chnl_rx_len),
      .CHNL_RX_OFF(chnl_rx_off), .CHNL_RX_DATA(chnl_rx_data),
      .CHNL_RX_DATA_VALID(chnl_rx_data_valid), .CHNL_RX_DATA_REN(ren1),
      .o_val(o_val1), .o_rdy(o_rdy1), .o_data(o_data1)
   );

   chnl_rx #(.C_PCI_DATA_WIDTH(PCI_W), .RX_WIDTH(96), .FIFO_DEPTH(DEPTH)) dut3 (
      .clk(clk), .rst(rst), .CHNL_RX_CLK(rx_clk3), .CHNL_RX(chnl_rx),
      .CHNL_RX_ACK(ack3), .CHNL_RX_LAST(chnl_rx_last), .CHNL_RX_LEN(chnl_rx_len),
      .CHNL_RX_OFF(chnl_rx_off), .CHNL_RX_DATA(chnl_rx_data),
      .CHNL_RX_DATA_VALID(valid3), .CHNL_RX_DATA_REN(ren3),
      .o_val(o_val3), .o_rdy(o_rdy3), .o_data(o_data3)
   );

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // One host transfer: request, wait for ack, offer beats (optionally abort
   // after max_beats), confirm no further beats are taken, then drop CHNL_RX.
   task automatic applyStimulus(input int unsigned len, input int max_beats,
                                input int valid_pct, output int accepted,
                                output bit ren_seen);
      int          nbeats, b, cyc;
      int unsigned widx;
      bit          got_ack;
      logic [31:0] base;
      nbeats   = (int'(len) + W - 1) / W;
      base     = $urandom() | 32'h8000_0000;
      accepted = 0;
      ren_seen = 1'b0;
      got_ack  = 1'b0;
      b        = 0;
      cyc      = 0;
      @(negedge clk);
      chnl_rx            = 1'b1;
      chnl_rx_len        = len;
      chnl_rx_off        = 31'($urandom());
      chnl_rx_data_valid = 1'b0;
      while (!got_ack && cyc < 20) begin
         @(negedge clk);
         #1;
         if (ren1) ren_seen = 1'b1;
         if (ack1) got_ack = 1'b1;
         cyc++;
      end
      if (!got_ack) begin
         checkOutput("ack_wait", 0, 1);
         chnl_rx = 1'b0;
         return;
      end
      cyc = 0;
      while (b < nbeats && !(max_beats >= 0 && b >= max_beats) && cyc < 2000) begin
         @(negedge clk);
         chnl_rx_data_valid = ($urandom_range(99) < valid_pct);
         for (int k = 0; k < W; k++) begin
            widx = b * W + k;
            chnl_rx_data[32*k +: 32] = (widx < len) ? (base ^ widx) : 32'h0000_DEAD;
         end
         #1;
         if (ren1) ren_seen = 1'b1;
         if (chnl_rx_data_valid && ren1) begin
            for (int k = 0; k < W; k++) begin
               widx = b * W + k;
               if (widx < len) begin
                  exp1.push_back(base ^ widx);
                  exp3.push_back(base ^ widx);
               end
            end
            b++;
            accepted++;
            beats_total++;
         end
         cyc++;
      end
      if (b < nbeats && !(max_beats >= 0 && b >= max_beats))
         checkOutput("beat_wait", b, nbeats);
      if (b == nbeats) begin
         repeat (2) begin
            @(negedge clk);
            chnl_rx_data_valid = 1'b1;
            #1;
            checkOutput("ren_done", ren1, 0);
         end
      end
      @(negedge clk);
      chnl_rx            = 1'b0;
      chnl_rx_data_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int cyc;
      cyc = 0;
      while ((exp1.size() != 0 || exp3.size() >= 3) && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      if (exp1.size() != 0 || exp3.size() >= 3)
         checkOutput("drain_wait", exp1.size(), 0);
      repeat (4) @(negedge clk);
   endtask

   // Downstream ready for the 32-bit instance
   initial begin
      o_rdy1 = 1'b1;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       o_rdy1 = 1'b1;
            1:       o_rdy1 = ($urandom_range(99) < 70);
            default: o_rdy1 = 1'b0;
         endcase
      end
   end

   // Output monitor and scoreboard for both instances
   initial begin
      logic        prev_val, prev_rdy, prev_rst;
      logic [31:0] prev_data;
      logic [95:0] e3;
      prev_val  = 1'b0;
      prev_rdy  = 1'b1;
      prev_rst  = 1'b1;
      prev_data = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (ack1) ack_count++;
            if (!prev_rst && prev_val && !prev_rdy) begin
               checkOutput("hold_val", o_val1, 1);
               checkOutput("hold_data", o_data1, prev_data);
            end
            if (o_val1 && o_rdy1) begin
               if (exp1.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("[TB] FAIL out1_extra: got %0h, expected no output", o_data1);
               end else begin
                  checkOutput("out1_data", o_data1, exp1.pop_front());
               end
               out_cnt1++;
            end
            if (o_val3 && o_rdy3) begin
               if (exp3.size() < 3) begin
                  vectors++;
                  miscompares++;
                  $display("[TB] FAIL out3_extra: got %0h, expected no output", o_data3);
               end else begin
                  e3[31:0]  = exp3.pop_front();
                  e3[63:32] = exp3.pop_front();
                  e3[95:64] = exp3.pop_front();
                  checkOutput("out3_data", o_data3, e3);
               end
               out_cnt3++;
            end
         end
         prev_val  = o_val1;
         prev_rdy  = o_rdy1;
         prev_rst  = rst;
         prev_data = o_data1;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t        vecs[5];
      int          acc, a0, o1, o3, b0, nb, mb;
      bit          rs;
      int unsigned len;

      vecs[0] = '{8, 4, 8, 1'b1};
      vecs[1] = '{5, 3, 5, 1'b1};
      vecs[2] = '{0, 0, 0, 1'b0};
      vecs[3] = '{1, 1, 1, 1'b1};
      vecs[4] = '{3, 2, 3, 1'b1};

      rst                = 1'b1;
      chnl_rx            = 1'b0;
      chnl_rx_last       = 1'b0;
      chnl_rx_len        = '0;
      chnl_rx_off        = '0;
      chnl_rx_data       = '0;
      chnl_rx_data_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_oval1", o_val1, 0);
      checkOutput("rst_oval3", o_val3, 0);
      checkOutput("rst_ack", ack1, 0);
      checkOutput("rst_ren1", ren1, 0);
      checkOutput("rst_ren3", ren3, 0);
      checkOutput("rx_clk1", rx_clk1, clk);
      checkOutput("rx_clk3", rx_clk3, clk);
      rst = 1'b0;

      // Two LEN=4 transfers into the 96-bit instance leave two words held
      o3 = out_cnt3;
      applyStimulus(4, -1, 100, acc, rs);
      applyStimulus(4, -1, 100, acc, rs);
      waitDrain();
      checkOutput("r3_outputs", out_cnt3 - o3, 2);
      checkOutput("r3_residual_oval", o_val3, 0);

      // Single-transfer table
      for (int i = 0; i < 5; i++) begin
         a0 = ack_count;
         o1 = out_cnt1;
         applyStimulus(vecs[i].len, -1, 100, acc, rs);
         waitDrain();
         checkOutput($sformatf("tbl%0d_beats", i), acc, vecs[i].beats);
         checkOutput($sformatf("tbl%0d_outputs", i), out_cnt1 - o1, vecs[i].outs);
         checkOutput($sformatf("tbl%0d_ren_seen", i), rs, vecs[i].ren);
         checkOutput($sformatf("tbl%0d_ack_cycles", i), ack_count - a0, 1);
      end

      // Backpressure: 20 beats with o_rdy low must stall, then drain in order
      rdy_mode = 2;
      o1 = out_cnt1;
      b0 = beats_total;
      fork
         applyStimulus(40, -1, 100, acc, rs);
         begin
            repeat (40) @(negedge clk);
            #2;
            checkOutput("bp_ren_low", ren1, 0);
            checkOutput("bp_stalled",
                        (beats_total - b0 >= DEPTH) && (beats_total - b0 < 20), 1);
            rdy_mode = 0;
         end
      join
      waitDrain();
      checkOutput("bp_outputs", out_cnt1 - o1, 40);

      // Host abort after two beats keeps those words
      o1 = out_cnt1;
      a0 = ack_count;
      applyStimulus(8, 2, 100, acc, rs);
      applyStimulus(2, -1, 100, acc, rs);
      waitDrain();
      checkOutput("abort_outputs", out_cnt1 - o1, 6);
      checkOutput("abort_acks", ack_count - a0, 2);

      // Reset in the middle of a transfer with three beats buffered
      rdy_mode = 2;
      @(negedge clk);
      chnl_rx            = 1'b1;
      chnl_rx_len        = 20;
      chnl_rx_data_valid = 1'b0;
      repeat (2) @(negedge clk);
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         chnl_rx_data_valid = 1'b1;
         for (int k = 0; k < W; k++)
            chnl_rx_data[32*k +: 32] = 32'hC000_0000 + 32'(b * W + k);
         #1;
         checkOutput("mid_ren", ren1, 1);
         if (ren1) begin
            for (int k = 0; k < W; k++) begin
               exp1.push_back(32'hC000_0000 + 32'(b * W + k));
               exp3.push_back(32'hC000_0000 + 32'(b * W + k));
            end
         end
      end
      @(negedge clk);
      rst                = 1'b1;
      chnl_rx            = 1'b0;
      chnl_rx_data_valid = 1'b0;
      exp1.delete();
      exp3.delete();
      @(negedge clk);
      #1;
      checkOutput("rst_mid_oval1", o_val1, 0);
      checkOutput("rst_mid_oval3", o_val3, 0);
      checkOutput("rst_mid_ack", ack1, 0);
      checkOutput("rst_mid_ren", ren1, 0);
      rst      = 1'b0;
      rdy_mode = 0;
      o1 = out_cnt1;
      applyStimulus(2, -1, 100, acc, rs);
      waitDrain();
      checkOutput("post_rst_outputs", out_cnt1 - o1, 2);

      // Randomized transfers with random valid, ready and occasional aborts
      rdy_mode = 1;
      for (int t = 0; t < 25; t++) begin
         len = $urandom_range(12);
         nb  = (int'(len) + W - 1) / W;
         mb  = ($urandom_range(9) == 0) ? int'($urandom_range(nb)) : -1;
         a0  = ack_count;
         applyStimulus(len, mb, 70, acc, rs);
         checkOutput("rnd_ack", ack_count - a0, 1);
      end
      rdy_mode = 0;
      waitDrain();
      checkOutput("final_oval1", o_val1, 0);
      checkOutput("final_oval3", o_val3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
